// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes a 128-bit state LANES bytes per clock.
// Optional macro SUBBYTES_PIPE_EN adds a register between the sbox lookups and the state write.
//
// state | meaning
// IDLE  | waiting for an input state, in_ready high
// SUB   | substituting LANES bytes per edge
// DONE  | result presented on out_state until out_ready
module sub_bytes_iter #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end

    // Index 0 is the leftmost entry, so SBOX[b] is the substitution of byte value b.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [0:15][7:0]      st_q, st_d;
    logic [4:0]            cnt_q;
    logic [0:LANES-1][7:0] lane_out;
    logic                  lookup;
    logic                  accept;
    logic                  sub_last;
    logic                  wr_en;
    logic [3:0]            wr_base;
    logic [0:LANES-1][7:0] wr_data;

    assign accept    = (state_q == IDLE) && in_valid;
    assign lookup    = (state_q == SUB) && (cnt_q < 5'd16);
    assign out_state = st_q;

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_out[k] = SBOX[st_q[cnt_q[3:0] + 4'(k)]];
        end
    end

`ifdef SUBBYTES_PIPE_EN
    logic                  pipe_vld_q;
    logic [3:0]            pipe_base_q;
    logic [0:LANES-1][7:0] pipe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q  <= 1'b0;
            pipe_base_q <= '0;
            pipe_q      <= '0;
        end else begin
            pipe_vld_q  <= lookup;
            pipe_base_q <= cnt_q[3:0];
            pipe_q      <= lane_out;
        end
    end

    assign wr_en    = pipe_vld_q;
    assign wr_base  = pipe_base_q;
    assign wr_data  = pipe_q;
    assign sub_last = pipe_vld_q && (pipe_base_q == 4'(16 - LANES));
`else
    assign wr_en    = lookup;
    assign wr_base  = cnt_q[3:0];
    assign wr_data  = lane_out;
    assign sub_last = lookup && (cnt_q == 5'(16 - LANES));
`endif

    always_comb begin
        st_d = st_q;
        if (accept) begin
            st_d = in_state;
        end else if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                st_d[wr_base + 4'(k)] = wr_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= '0;
            cnt_q <= '0;
        end else begin
            st_q <= st_d;
            if (accept) begin
                cnt_q <= '0;
            end else if (lookup) begin
                cnt_q <= cnt_q + 5'(LANES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = SUB;
                end
            end
            SUB: begin
                if (sub_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: GF(2^8)-derived sbox model, latency-countdown reference,
// directed vectors and randomized handshake traffic.
module tb_sub_bytes_iter;

    localparam int LANES = 4;
`ifdef SUBBYTES_PIPE_EN
    localparam int LAT = 16 / LANES + 1;
`else
    localparam int LAT = 16 / LANES;
`endif
    localparam int M_IDLE = 0;
    localparam int M_WORK = 1;
    localparam int M_DONE = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 0;

    logic [7:0] sb_m [256];

    int           m_state = M_IDLE;
    int           m_left = 0;
    bit           m_zero = 0;
    logic [127:0] m_res = '0;

    sub_bytes_iter #(.LANES(LANES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [7:0] r = x;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] b);
        logic [7:0] inv = 0;
        for (int x = 1; x < 256; x++) begin
            if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_all(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb_m[d[127-8*i -: 8]];
        return r;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%b required=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Reference: accept in idle, result appears LAT edges later, held until taken.
    always @(posedge clk) begin
        if (rst) begin
            m_state = M_IDLE;
            m_zero  = 1;
        end else begin
            case (m_state)
                M_IDLE: if (in_valid) begin
                    m_res   = sub_all(in_state);
                    m_left  = LAT;
                    m_state = M_WORK;
                    m_zero  = 0;
                end
                M_WORK: begin
                    m_left--;
                    if (m_left == 0) m_state = M_DONE;
                end
                default: if (out_ready) m_state = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk_bit("in_ready", in_ready, m_state == M_IDLE);
            chk_bit("out_valid", out_valid, m_state == M_DONE);
            chk_bit("busy", busy, m_state != M_IDLE);
            if (m_state == M_DONE) chk_vec("out_state", out_state, m_res);
            else if (m_zero) chk_vec("out_state_reset", out_state, '0);
        end
    end

    task automatic send(input logic [127:0] d, output int acc);
        in_state = d;
        in_valid = 1;
        for (int i = 0; i < 100 && in_ready !== 1'b1; i++) @(negedge clk);
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_timeout t=%0d actual=in_ready_low required=in_ready_high", cyc);
        end
        @(negedge clk);
        acc = cyc;
        in_valid = 0;
    endtask

    task automatic wait_out(output int t);
        for (int i = 0; i < 100 && out_valid !== 1'b1; i++) @(negedge clk);
        if (out_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL out_timeout t=%0d actual=out_valid_low required=out_valid_high", cyc);
        end
        t = cyc;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, acc2, t;
        logic [127:0] v, v2, rec, ramp;
        rst = 1; in_valid = 0; out_ready = 0; in_state = '0;
        for (int b = 0; b < 256; b++) sb_m[b] = sbox_calc(8'(b));
        chk_vec("model_sbox_00", {120'd0, sb_m[8'h00]}, 128'h63);
        chk_vec("model_sbox_ff", {120'd0, sb_m[8'hff]}, 128'h16);
        chk_vec("model_sbox_53", {120'd0, sb_m[8'h53]}, 128'hed);
        chk_vec("model_sbox_01", {120'd0, sb_m[8'h01]}, 128'h7c);

        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        rst = 0;

        // FIPS-197 vector
        out_ready = 1;
        send(128'h193de3bea0f4e22b9ac68d2ae9f84808, acc);
        wait_out(t);
        chk_vec("fips_result", out_state, 128'hd42711aee0bf98f1b8b45de51e415230);
        chk_vec("fips_latency", 128'(t - acc), 128'(LAT));

        // byte extremes
        send('0, acc);
        wait_out(t);
        chk_vec("zeros", out_state, {16{8'h63}});
        send({16{8'hff}}, acc);
        wait_out(t);
        chk_vec("ones", out_state, {16{8'h16}});
        for (int i = 0; i < 16; i++) ramp[127-8*i -: 8] = 8'(i);
        send(ramp, acc);
        wait_out(t);
        chk_vec("ramp_b0", {120'd0, out_state[127:120]}, 128'h63);
        chk_vec("ramp_b1", {120'd0, out_state[119:112]}, 128'h7c);
        chk_vec("ramp_b15", {120'd0, out_state[7:0]}, 128'h76);
        chk_vec("ramp_latency", 128'(t - acc), 128'(LAT));

        // back-pressure
        @(negedge clk);
        out_ready = 0;
        v = {$urandom, $urandom, $urandom, $urandom};
        send(v, acc);
        wait_out(t);
        rec = out_state;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_bit("stall_valid", out_valid, 1'b1);
            chk_bit("stall_in_ready", in_ready, 1'b0);
            chk_vec("stall_state", out_state, rec);
        end
        out_ready = 1;
        @(negedge clk);
        chk_bit("release_valid", out_valid, 1'b0);
        chk_bit("release_in_ready", in_ready, 1'b1);

        // input ignored while busy
        v = {$urandom, $urandom, $urandom, $urandom};
        v2 = ~v;
        send(v, acc);
        in_state = v2;
        in_valid = 1;
        wait_out(t);
        chk_vec("busy_first", out_state, sub_all(v));
        send(v2, acc2);
        chk_bit("busy_second_after", acc2 > t, 1'b1);
        wait_out(t);
        chk_vec("busy_second", out_state, sub_all(v2));

        // reset mid-operation
        @(negedge clk);
        send({$urandom, $urandom, $urandom, $urandom}, acc);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk_bit("rst_out_valid", out_valid, 1'b0);
        chk_bit("rst_in_ready", in_ready, 1'b1);
        chk_bit("rst_busy", busy, 1'b0);
        chk_vec("rst_out_state", out_state, '0);
        send({16{8'h53}}, acc);
        wait_out(t);
        chk_vec("after_rst", out_state, {16{8'hed}});

        // back-to-back
        @(negedge clk);
        send({$urandom, $urandom, $urandom, $urandom}, acc);
        v2 = {$urandom, $urandom, $urandom, $urandom};
        send(v2, acc2);
        chk_vec("b2b_spacing", 128'(acc2 - acc), 128'(LAT + 2));
        wait_out(t);
        chk_vec("b2b_second", out_state, sub_all(v2));

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 6);
            rst       = ($urandom_range(0, 49) == 0);
        end
        @(negedge clk);
        rst = 0; in_valid = 0; out_ready = 1;
        repeat (LAT + 4) @(negedge clk);
        chk_bit("drain_idle", in_ready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
